// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC sequencer.
package pc_pkg;

  // Widest PC the alignment helper supports.
  localparam int unsigned ADDR_MAX_W = 64;

  // BOOT: first cycle out of reset, RUN: nothing buffered, PEND: one redirect buffered.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  // Number of always-zero low PC bits implied by a power-of-two step.
  function automatic int unsigned align_bits_of(input int unsigned step);
    return $clog2(step);
  endfunction

  // Clear the low align_bits bits of an address.
  function automatic logic [ADDR_MAX_W-1:0] align_addr(
    input logic [ADDR_MAX_W-1:0] addr,
    input int unsigned           align_bits
  );
    logic [ADDR_MAX_W-1:0] mask;
    mask = ~((ADDR_MAX_W'(1) << align_bits) - ADDR_MAX_W'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry redirect buffer: capture overwrites, clear empties, sync reset.
module pc_redirect_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic [WIDTH-1:0] capture_addr,
  input  logic             clear,
  output logic             valid_q,
  output logic [WIDTH-1:0] addr_q
);

  logic             valid_d;
  logic [WIDTH-1:0] addr_d;

  // Capture wins over clear; a newer capture overwrites the held target.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (capture) begin
      valid_d = 1'b1;
      addr_d  = capture_addr;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  // Buffer storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential step, stall, buffered redirects, exceptions.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0080),
  parameter int unsigned      STEP      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exception,
  output logic [WIDTH-1:0] pc_q,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             pc_valid,
  output logic             redirect_pending,
  output logic             misaligned
);

  // STEP must be a power of two; its log2 is the count of forced-zero PC bits.
  localparam int unsigned ALIGN_BITS = align_bits_of(STEP);

  state_e           state_q;
  state_e           state_d;

  logic [WIDTH-1:0] pc_d;
  logic             pc_valid_q;
  logic             pc_valid_d;
  logic             redirect_pending_q;
  logic             redirect_pending_d;
  logic             misaligned_q;
  logic             misaligned_d;

  logic             buf_capture;
  logic             buf_clear;
  logic             buf_valid;
  logic [WIDTH-1:0] buf_addr;

  logic [WIDTH-1:0] target_aligned;
  logic             target_misaligned;

  // Redirect target with the low ALIGN_BITS forced to zero.
  assign target_aligned    = WIDTH'(align_addr(ADDR_MAX_W'(redirect_target), ALIGN_BITS));
  assign target_misaligned = (redirect_target != target_aligned);

  // Sequential successor, wrapping modulo 2^WIDTH.
  assign pc_plus_step = pc_q + WIDTH'(STEP);

  pc_redirect_buf #(
    .WIDTH (WIDTH)
  ) u_redirect_buf (
    .clk          (clk),
    .reset        (reset),
    .capture      (buf_capture),
    .capture_addr (target_aligned),
    .clear        (buf_clear),
    .valid_q      (buf_valid),
    .addr_q       (buf_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: exception or unstalled cycle returns to RUN, stalled redirect parks in PEND.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN, PEND: begin
        if (exception) begin
          state_d = RUN;
        end else if (stall) begin
          if (redirect_valid) begin
            state_d = PEND;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Priority mux for the next PC plus buffer control and status flags.
  always_comb begin
    pc_d               = pc_q;
    pc_valid_d         = pc_valid_q;
    misaligned_d       = 1'b0;
    buf_capture        = 1'b0;
    buf_clear          = 1'b0;
    redirect_pending_d = (state_d == PEND);
    unique case (state_q)
      BOOT: begin
        // Only an exception is honoured while leaving boot.
        pc_valid_d = 1'b1;
        pc_d       = exception ? EXC_VEC : RESET_VEC;
        buf_clear  = 1'b1;
      end
      RUN, PEND: begin
        pc_valid_d = 1'b1;
        if (exception) begin
          pc_d      = EXC_VEC;
          buf_clear = 1'b1;
        end else if (stall) begin
          if (redirect_valid) begin
            buf_capture  = 1'b1;
            misaligned_d = target_misaligned;
          end
        end else if (redirect_valid) begin
          pc_d         = target_aligned;
          buf_clear    = 1'b1;
          misaligned_d = target_misaligned;
        end else if ((state_q == PEND) && buf_valid) begin
          pc_d      = buf_addr;
          buf_clear = 1'b1;
        end else begin
          pc_d = pc_plus_step;
        end
      end
      default: begin
        pc_d = RESET_VEC;
      end
    endcase
  end

  // PC and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q               <= RESET_VEC;
      pc_valid_q         <= 1'b0;
      redirect_pending_q <= 1'b0;
      misaligned_q       <= 1'b0;
    end else begin
      pc_q               <= pc_d;
      pc_valid_q         <= pc_valid_d;
      redirect_pending_q <= redirect_pending_d;
      misaligned_q       <= misaligned_d;
    end
  end

  assign pc_valid         = pc_valid_q;
  assign redirect_pending = redirect_pending_q;
  assign misaligned       = misaligned_q;

endmodule
